// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl - multi-cycle Hack CPU controller.
//
// Fetches 16-bit Hack instructions, sequences them through a small FSM,
// drives the external combinational ALU and owns the A, D and PC registers
// plus the instruction/data memory request-acknowledge handshakes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/    data memory handshake (addr = A[14:0])
//   dmem_ack/rdata
//   alu_x, alu_y, alu_zx..no   ALU operands and controls (from instr)
//   alu_out, alu_zr, alu_ng    ALU result and flags
//   pc, a_reg, d_reg           architectural state
//   instr_done                 one-cycle pulse when an instruction retires
//
// All outputs are decoded from registered state only.

module hack_cpu_ctrl #(
    parameter int WIDTH = 16,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [AW-1:0]    dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic [AW-1:0]    pc,
    output logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] d_reg,
    output logic             instr_done
);

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE,
        COMMIT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, d_q, instr_q, m_q, res_q;
    logic [AW-1:0]    pc_q;
    logic             zr_q, ng_q;
    logic             jump;
    logic             is_c_instr;
    logic             unused_instr_bits;

    assign is_c_instr = instr_q[15];

    // instr[14:13] carry no meaning in the Hack ISA
    assign unused_instr_bits = ^instr_q[14:13];

    // Evaluated from the flags latched in EXEC
    assign jump = (instr_q[2] & ng_q)
                | (instr_q[1] & zr_q)
                | (instr_q[0] & ~ng_q & ~zr_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:   state_nxt = FETCH;
            FETCH:  if (imem_ack) state_nxt = DECODE;
            DECODE: begin
                if (!is_c_instr)      state_nxt = FETCH;
                else if (instr_q[12]) state_nxt = MREAD;
                else                  state_nxt = EXEC;
            end
            MREAD:  if (dmem_ack) state_nxt = EXEC;
            EXEC:   state_nxt = instr_q[3] ? MWRITE : COMMIT;
            MWRITE: if (dmem_ack) state_nxt = COMMIT;
            COMMIT: state_nxt = FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            m_q     <= '0;
            res_q   <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) instr_q <= imem_rdata;
                end
                DECODE: begin
                    if (!is_c_instr) begin
                        a_q  <= WIDTH'(instr_q[AW-1:0]);
                        pc_q <= pc_q + AW'(1);
                    end
                end
                MREAD: begin
                    if (dmem_ack) m_q <= dmem_rdata;
                end
                EXEC: begin
                    res_q <= alu_out;
                    zr_q  <= alu_zr;
                    ng_q  <= alu_ng;
                end
                COMMIT: begin
                    // Jump target and the MWRITE address both see A as it was
                    // before this instruction; A's own update lands here.
                    if (instr_q[5]) a_q <= res_q;
                    if (instr_q[4]) d_q <= res_q;
                    pc_q <= jump ? a_q[AW-1:0] : pc_q + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // ------------------------------------------------------------------
    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state == MREAD) || (state == MWRITE);
    assign dmem_we    = (state == MWRITE);
    assign dmem_addr  = a_q[AW-1:0];
    assign dmem_wdata = res_q;

    assign alu_x  = d_q;
    assign alu_y  = instr_q[12] ? m_q : a_q;
    assign alu_zx = instr_q[11];
    assign alu_nx = instr_q[10];
    assign alu_zy = instr_q[9];
    assign alu_ny = instr_q[8];
    assign alu_f  = instr_q[7];
    assign alu_no = instr_q[6];

    assign pc    = pc_q;
    assign a_reg = a_q;
    assign d_reg = d_q;

    assign instr_done = ((state == DECODE) && !is_c_instr) || (state == COMMIT);

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Testbench for hack_cpu_ctrl: Hack ALU model, zero-wait instruction memory,
// data memory with programmable ack delay, directed programs with
// hand-computed expectations.

module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack;
    logic [14:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;
    logic        instr_done;

    hack_cpu_ctrl #(.WIDTH(16), .AW(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // Hack ALU model
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = alu_zx ? 16'h0000 : alu_x;
        ax = alu_nx ? ~ax : ax;
        ay = alu_zy ? 16'h0000 : alu_y;
        ay = alu_ny ? ~ay : ay;
        ao = alu_f ? (ax + ay) : (ax & ay);
        ao = alu_no ? ~ao : ao;
    end
    assign alu_out = ao;
    assign alu_zr  = (ao == 16'h0000);
    assign alu_ng  = ao[15];

    // Instruction memory: zero-wait
    logic [15:0] imem [0:32767];
    assign imem_ack   = imem_req;
    assign imem_rdata = imem[imem_addr];

    // Data memory: reads from preloaded array, writes logged
    logic [15:0] dmem [0:32767];
    int unsigned dwait = 0;
    int unsigned dcnt = 0;
    int unsigned wr_count = 0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    assign dmem_ack   = dmem_req && (dcnt >= dwait);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else                       dcnt <= 0;
        if (dmem_req && dmem_we && dmem_ack) begin
            wr_count <= wr_count + 1;
            wr_addr  <= dmem_addr;
            wr_data  <= dmem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs until the next retire pulse, then one more cycle so the commit is visible
    task automatic run_one(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (instr_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_retire"}, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dwait = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_imem();
        for (int unsigned i = 0; i < 128; i++) imem[i] = 16'h0000;
    endtask

    int unsigned w0;
    int          req_cyc;
    int          bad_cyc;
    bit          seen;

    initial begin
        for (int unsigned i = 0; i < 32768; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = 16'h0000;
        end

        // ---------------- Test 1/2: A-instr, D=A, D=D+A ----------------
        imem[0] = 16'h0011;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0003;
        imem[3] = 16'hE090;
        rst_n = 1'b0;
        tick();
        check_eq("rst_a",    32'(a_reg),      32'h0);
        check_eq("rst_d",    32'(d_reg),      32'h0);
        check_eq("rst_pc",   32'(pc),         32'h0);
        check_eq("rst_ireq", 32'(imem_req),   32'h0);
        check_eq("rst_dreq", 32'(dmem_req),   32'h0);
        check_eq("rst_done", 32'(instr_done), 32'h0);
        rst_n = 1'b1;
        check_eq("boot_ireq", 32'(imem_req), 32'h0);
        tick();
        check_eq("fetch_ireq", 32'(imem_req),  32'h1);
        check_eq("fetch_addr", 32'(imem_addr), 32'h0);
        tick();
        check_eq("ainst_done", 32'(instr_done), 32'h1);
        check_eq("ainst_ireq", 32'(imem_req),   32'h0);
        tick();
        check_eq("ainst_a",     32'(a_reg),      32'h0011);
        check_eq("ainst_pc",    32'(pc),         32'h1);
        check_eq("ainst_done0", 32'(instr_done), 32'h0);
        tick();
        tick();
        check_eq("exec_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'b110000);
        check_eq("exec_y", 32'(alu_y), 32'h0011);
        tick();
        check_eq("commit_done", 32'(instr_done), 32'h1);
        tick();
        check_eq("deqa_d",  32'(d_reg), 32'h0011);
        check_eq("deqa_pc", 32'(pc),    32'h2);
        run_one("i2");
        run_one("i3");
        check_eq("add_d",  32'(d_reg), 32'h0014);
        check_eq("add_a",  32'(a_reg), 32'h0003);
        check_eq("add_pc", 32'(pc),    32'h4);

        // ---------------- Test 3: M=D with 3 wait cycles ----------------
        clear_imem();
        imem[0] = 16'h0014;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0100;
        imem[3] = 16'hE308;
        do_reset();
        run_one("w0");
        run_one("w1");
        run_one("w2");
        dwait = 3;
        w0 = wr_count;
        req_cyc = 0;
        bad_cyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dmem_req) begin
                req_cyc++;
                if (!dmem_we || dmem_addr != 15'h0100 || dmem_wdata != 16'h0014) bad_cyc++;
            end
            if (instr_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("mw_retire",  32'(seen),    32'h1);
        check_eq("mw_reqcyc",  32'(req_cyc), 32'd4);
        check_eq("mw_stable",  32'(bad_cyc), 32'd0);
        tick();
        check_eq("mw_count", wr_count - w0,   32'd1);
        check_eq("mw_addr",  32'(wr_addr),    32'h0100);
        check_eq("mw_data",  32'(wr_data),    32'h0014);
        check_eq("mw_a",     32'(a_reg),      32'h0100);
        check_eq("mw_d",     32'(d_reg),      32'h0014);
        check_eq("mw_pc",    32'(pc),         32'h4);
        dwait = 0;

        // ---------------- Test 4: D=M ----------------
        clear_imem();
        imem[0] = 16'h0100;
        imem[1] = 16'hFC10;
        dmem[15'h0100] = 16'hFFFE;
        do_reset();
        run_one("r0");
        w0 = wr_count;
        tick();
        tick();
        check_eq("mr_req", 32'(dmem_req), 32'h1);
        check_eq("mr_we",  32'(dmem_we),  32'h0);
        check_eq("mr_addr", 32'(dmem_addr), 32'h0100);
        tick();
        check_eq("mr_y", 32'(alu_y), 32'hFFFE);
        tick();
        check_eq("mr_done", 32'(instr_done), 32'h1);
        tick();
        check_eq("mr_d",     32'(d_reg),    32'hFFFE);
        check_eq("mr_nowr",  wr_count - w0, 32'd0);
        check_eq("mr_pc",    32'(pc),       32'h2);

        // ---------------- Test 5: jumps and PC wrap ----------------
        clear_imem();
        imem[0]  = 16'hEE90;
        imem[1]  = 16'hE390;
        imem[2]  = 16'h0020;
        imem[3]  = 16'hE304;
        imem[32] = 16'hEA90;
        imem[33] = 16'hE304;
        imem[34] = 16'h0030;
        imem[35] = 16'hEA87;
        imem[48] = 16'h7FFF;
        imem[49] = 16'hEA87;
        imem[32767] = 16'hEA90;
        do_reset();
        run_one("j0");
        run_one("j1");
        check_eq("j_dneg", 32'(d_reg), 32'hFFFE);
        run_one("j2");
        run_one("j3");
        check_eq("jlt_taken", 32'(pc), 32'h0020);
        run_one("j4");
        run_one("j5");
        check_eq("jlt_nottaken", 32'(pc), 32'h0022);
        run_one("j6");
        run_one("j7");
        check_eq("jmp_pc", 32'(pc), 32'h0030);
        run_one("j8");
        run_one("j9");
        check_eq("jmp_7fff", 32'(pc), 32'h7FFF);
        run_one("j10");
        check_eq("pc_wrap", 32'(pc), 32'h0000);

        // ---------------- Test 6: AM=D old-A write, A=D;JMP old-A target ----------------
        clear_imem();
        imem[0] = 16'h0005;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0040;
        imem[3] = 16'hE328;
        imem[4] = 16'h0050;
        imem[5] = 16'hE327;
        do_reset();
        run_one("am0");
        run_one("am1");
        run_one("am2");
        w0 = wr_count;
        run_one("am3");
        check_eq("am_count", wr_count - w0, 32'd1);
        check_eq("am_addr",  32'(wr_addr),  32'h0040);
        check_eq("am_data",  32'(wr_data),  32'h0005);
        check_eq("am_a",     32'(a_reg),    32'h0005);
        run_one("am4");
        run_one("am5");
        check_eq("ajmp_pc", 32'(pc),    32'h0050);
        check_eq("ajmp_a",  32'(a_reg), 32'h0005);

        // ---------------- Test 7: reset during MWRITE wait ----------------
        clear_imem();
        imem[0] = 16'h0007;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0100;
        imem[3] = 16'hE308;
        do_reset();
        run_one("rs0");
        run_one("rs1");
        run_one("rs2");
        dwait = 10;
        w0 = wr_count;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dmem_req) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rs_mwreq", 32'(seen), 32'h1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rs_dreq", 32'(dmem_req),   32'h0);
        check_eq("rs_a",    32'(a_reg),      32'h0);
        check_eq("rs_d",    32'(d_reg),      32'h0);
        check_eq("rs_pc",   32'(pc),         32'h0);
        check_eq("rs_done", 32'(instr_done), 32'h0);
        tick();
        tick();
        check_eq("rs_nowr", wr_count - w0, 32'd0);
        dwait = 0;
        rst_n = 1'b1;
        tick();
        check_eq("rs_ireq", 32'(imem_req),  32'h1);
        check_eq("rs_iadr", 32'(imem_addr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
